// File: rtl/vt100_decoder.sv
// VT100/ANSI subset decoder: turns received UART bytes into character-buffer
// writes and tracks the cursor for the display overlay.
module vt100_decoder #(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_v,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_wdata,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_busy,
  output logic              o_err
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam logic [8:0]      ROW_MAX  = 9'(ROWS - 1);
  localparam logic [8:0]      COL_MAX  = 9'(COLS - 1);
  localparam logic [ADDR_W:0] CLR_END  = (ADDR_W + 1)'(CELLS);

  typedef enum logic [2:0] {IDLE, ESC, CSI1, CSI2, CLEAR} state_t;

  state_t          state_reg;
  logic [RW-1:0]   row_reg;
  logic [CW-1:0]   col_reg;
  logic [7:0]      p1_reg, p2_reg;
  logic [ADDR_W:0] clr_reg;

  logic [ADDR_W-1:0] cursor;
  logic [8:0]  row9, col9, n9, row_up, row_dn, col_rt, col_lt, p1m, p2m, h_row, h_col;
  logic [7:0]  par;
  logic [11:0] acc;
  logic [7:0]  acc_sat;
  logic        is_digit, is_print;
  logic [RW-1:0] adv_row, lf_row;
  logic [CW-1:0] adv_col, bs_col;

  assign cursor   = ADDR_W'(row_reg) * ADDR_W'(COLS) + ADDR_W'(col_reg);
  assign o_cursor = cursor;

  // Clamp arithmetic is 9 bits wide so position +/- 255 never wraps.
  always_comb begin
    row9     = 9'(row_reg);
    col9     = 9'(col_reg);
    n9       = (p1_reg == 8'd0) ? 9'd1 : {1'b0, p1_reg};
    row_up   = (n9 >= row9) ? 9'd0 : row9 - n9;
    row_dn   = (row9 + n9 >= ROW_MAX) ? ROW_MAX : row9 + n9;
    col_lt   = (n9 >= col9) ? 9'd0 : col9 - n9;
    col_rt   = (col9 + n9 >= COL_MAX) ? COL_MAX : col9 + n9;
    p1m      = (p1_reg == 8'd0) ? 9'd0 : {1'b0, p1_reg} - 9'd1;
    p2m      = (p2_reg == 8'd0) ? 9'd0 : {1'b0, p2_reg} - 9'd1;
    h_row    = (p1m >= ROW_MAX) ? ROW_MAX : p1m;
    h_col    = (p2m >= COL_MAX) ? COL_MAX : p2m;
    is_digit = (i_byte >= 8'h30) && (i_byte <= 8'h39);
    is_print = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
    par      = (state_reg == CSI2) ? p2_reg : p1_reg;
    acc      = 12'(par) * 12'd10 + {4'd0, i_byte - 8'h30};
    acc_sat  = (acc > 12'd255) ? 8'hFF : acc[7:0];
    lf_row   = (row_reg == RW'(ROWS - 1)) ? '0 : row_reg + RW'(1);
    bs_col   = (col_reg == '0) ? '0 : col_reg - CW'(1);
    if (col_reg == CW'(COLS - 1)) begin
      adv_col = '0;
      adv_row = lf_row;
    end else begin
      adv_col = col_reg + CW'(1);
      adv_row = row_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      p1_reg    <= '0;
      p2_reg    <= '0;
      clr_reg   <= '0;
      o_wen     <= 1'b0;
      o_addr    <= '0;
      o_wdata   <= '0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_wen <= 1'b0;
      o_err <= 1'b0;
      case (state_reg)
        IDLE: if (i_byte_v) begin
          if (is_print) begin
            o_wen   <= 1'b1;
            o_addr  <= cursor;
            o_wdata <= i_byte;
            row_reg <= adv_row;
            col_reg <= adv_col;
          end else if (i_byte == 8'h0D) col_reg <= '0;
          else if (i_byte == 8'h0A) row_reg <= lf_row;
          else if (i_byte == 8'h08) col_reg <= bs_col;
          else if (i_byte == 8'h1B) state_reg <= ESC;
        end
        ESC: if (i_byte_v) begin
          if (i_byte == 8'h5B) begin
            state_reg <= CSI1;
            p1_reg    <= '0;
            p2_reg    <= '0;
          end else if (i_byte != 8'h1B) begin
            o_err     <= 1'b1;
            state_reg <= IDLE;
          end
        end
        CSI1, CSI2: if (i_byte_v) begin
          if (is_digit) begin
            if (state_reg == CSI2) p2_reg <= acc_sat;
            else                   p1_reg <= acc_sat;
          end else if (i_byte == 8'h3B) begin
            if (state_reg == CSI1) state_reg <= CSI2;
            else begin
              o_err     <= 1'b1;
              state_reg <= IDLE;
            end
          end else if (i_byte == 8'h1B) begin
            state_reg <= ESC;
          end else begin
            state_reg <= IDLE;
            case (i_byte)
              8'h41: row_reg <= row_up[RW-1:0];
              8'h42: row_reg <= row_dn[RW-1:0];
              8'h43: col_reg <= col_rt[CW-1:0];
              8'h44: col_reg <= col_lt[CW-1:0];
              8'h48: begin
                row_reg <= h_row[RW-1:0];
                col_reg <= h_col[CW-1:0];
              end
              8'h4A: if (p1_reg == 8'd2) begin
                // First blank goes out on the same edge that enters CLEAR.
                state_reg <= CLEAR;
                o_busy    <= 1'b1;
                o_wen     <= 1'b1;
                o_addr    <= '0;
                o_wdata   <= 8'h20;
                clr_reg   <= (ADDR_W + 1)'(1);
              end
              default: o_err <= 1'b1;
            endcase
          end
        end
        CLEAR: begin
          if (i_byte_v) o_err <= 1'b1;
          if (clr_reg == CLR_END) begin
            state_reg <= IDLE;
            o_busy    <= 1'b0;
            row_reg   <= '0;
            col_reg   <= '0;
          end else begin
            o_wen   <= 1'b1;
            o_addr  <= clr_reg[ADDR_W-1:0];
            o_wdata <= 8'h20;
            clr_reg <= clr_reg + (ADDR_W + 1)'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vt100_decoder.sv
// Self-checking bench for vt100_decoder: buffer writes are predicted into a
// scoreboard queue and popped by a monitor; cursor/flags are checked inline.
module tb_vt100_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_v = 1'b0;
  logic       o_wen, o_busy, o_err;
  logic [9:0] o_addr, o_cursor;
  logic [7:0] o_wdata;

  int total = 0;
  int bad = 0;
  logic [17:0] sb[$];

  vt100_decoder #(.COLS(40), .ROWS(25), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v),
    .o_wen(o_wen), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_cursor(o_cursor), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_wen === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%h want no write", o_addr, o_wdata);
      end else begin
        automatic logic [17:0] e = sb.pop_front();
        if ({o_addr, o_wdata} !== e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   o_addr, o_wdata, e[17:8], e[7:0]);
        end else
          $display("write addr=%0d data=%h", o_addr, o_wdata);
      end
    end
  end

  task automatic put(input logic [7:0] b);
    i_byte = b;
    i_byte_v = 1'b1;
    @(negedge clk);
    i_byte_v = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic csi(input string s);
    put(8'h1B);
    put(8'h5B);
    send(s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_cursor(input string name, input logic [9:0] want);
    total++;
    if (o_cursor !== want) begin
      bad++;
      $display("FAIL %s cursor got=%0d want=%0d", name, o_cursor, want);
    end else
      $display("%s cursor=%0d", name, o_cursor);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle(3);
    total++; if (o_wen !== 1'b0)    begin bad++; $display("FAIL reset_wen got=%b want=0", o_wen); end
    total++; if (o_addr !== 10'd0)  begin bad++; $display("FAIL reset_addr got=%0d want=0", o_addr); end
    total++; if (o_wdata !== 8'd0)  begin bad++; $display("FAIL reset_wdata got=%h want=00", o_wdata); end
    total++; if (o_busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b want=0", o_err); end
    chk_cursor("reset", 10'd0);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_print;
    sb.push_back({10'd0, 8'h48});
    sb.push_back({10'd1, 8'h69});
    send("Hi");
    chk_cursor("print_hi", 10'd2);
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL print_err got=%b want=0", o_err); end
  endtask

  task automatic test_cup;
    csi("5;10H");
    chk_cursor("cup_5_10", 10'd169);
    sb.push_back({10'd169, 8'h58});
    put("X");
    chk_cursor("cup_after_x", 10'd170);
    csi("99;99H");
    chk_cursor("cup_clamp", 10'd999);
  endtask

  task automatic test_moves;
    csi("H");     chk_cursor("home", 10'd0);
    csi("3B");    chk_cursor("down3", 10'd120);
    csi("2C");    chk_cursor("right2", 10'd122);
    csi("A");     chk_cursor("up1", 10'd82);
    csi("50D");   chk_cursor("left50", 10'd80);
    csi("H");
    csi("300B");  chk_cursor("down_sat", 10'd960);
    csi("999C");  chk_cursor("right_sat", 10'd999);
  endtask

  task automatic test_wrap;
    csi("25;40H");
    sb.push_back({10'd999, 8'h5A});
    put("Z");
    chk_cursor("last_cell_wrap", 10'd0);
    csi("25;1H");
    chk_cursor("row24", 10'd960);
    put(8'h0A);
    chk_cursor("lf_wrap", 10'd0);
    sb.push_back({10'd0, 8'h61});
    sb.push_back({10'd1, 8'h62});
    send("ab");
    put(8'h0D);
    chk_cursor("cr", 10'd0);
    put(8'h08);
    chk_cursor("bs_sat", 10'd0);
    sb.push_back({10'd0, 8'h63});
    put("c");
    put(8'h08);
    chk_cursor("bs", 10'd0);
  endtask

  task automatic test_clear;
    int busy_cnt;
    csi("1;6H");
    chk_cursor("pre_clear", 10'd5);
    for (int a = 0; a < 1000; a++) sb.push_back({10'(a), 8'h20});
    put(8'h1B);
    send("[2");
    put("J");
    busy_cnt = 0;
    while (o_busy === 1'b1 && busy_cnt < 2000) begin
      busy_cnt++;
      if (busy_cnt == 10) begin
        i_byte = "Q";
        i_byte_v = 1'b1;
      end else
        i_byte_v = 1'b0;
      @(negedge clk);
      if (busy_cnt == 10) begin
        total++;
        if (o_err !== 1'b1) begin bad++; $display("FAIL clear_drop_err got=%b want=1", o_err); end
      end
    end
    i_byte_v = 1'b0;
    total++; if (busy_cnt != 1000) begin bad++; $display("FAIL clear_busy_cycles got=%0d want=1000", busy_cnt); end
    chk_cursor("post_clear", 10'd0);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL clear_writes_left got=%0d want=0", sb.size()); end
    idle(2);
  endtask

  task automatic test_errors;
    put(8'h1B);
    put("x");
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL esc_x_err got=%b want=1", o_err); end
    sb.push_back({10'd0, 8'h41});
    put("A");
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL idle_err got=%b want=0", o_err); end
    chk_cursor("after_esc_x", 10'd1);
    put(8'h1B);
    send("[1;2");
    put(";");
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL second_semi_err got=%b want=1", o_err); end
    sb.push_back({10'd1, 8'h33});
    sb.push_back({10'd2, 8'h48});
    send("3H");
    chk_cursor("after_semi", 10'd3);
    csi("5Z");
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL bad_final_err got=%b want=1", o_err); end
    chk_cursor("bad_final", 10'd3);
    put(8'h1B);
    send("[5");
    put(8'h1B);
    send("[C");
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL esc_restart_err got=%b want=0", o_err); end
    chk_cursor("esc_restart", 10'd4);
  endtask

  task automatic test_reset_mid_clear;
    csi("2;6H");
    chk_cursor("pre_abort", 10'd45);
    for (int a = 0; a < 5; a++) sb.push_back({10'(a), 8'h20});
    put(8'h1B);
    send("[2");
    put("J");
    idle(4);
    rst = 1'b0;
    @(negedge clk);
    total++; if (o_wen !== 1'b0)  begin bad++; $display("FAIL abort_wen got=%b want=0", o_wen); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", o_busy); end
    chk_cursor("abort", 10'd0);
    rst = 1'b1;
    idle(5);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL abort_writes_left got=%0d want=0", sb.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_print;
    test_cup;
    test_moves;
    test_wrap;
    test_clear;
    test_errors;
    test_reset_mid_clear;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
